// File: rtl/extended_hamming_error_logger_pkg.sv
// Shared types and event classification for the extended Hamming error logger.
package extended_hamming_error_logger_pkg;

    typedef enum logic {
        ERROR_CORRECTABLE   = 1'b0,
        ERROR_UNCORRECTABLE = 1'b1
    } error_type_t;

    // Turns raw checker flags into per-cycle counter increments {inc_correctable, inc_uncorrectable}.
    // A double-bit flag dominates: a word is never counted as both kinds.
    function automatic logic [1:0] classify(input logic valid,
                                            input logic correctable,
                                            input logic uncorrectable);
        logic [1:0] result;
        result = 2'b00;
        if (valid) begin
            if (uncorrectable) begin
                result = 2'b01;
            end else if (correctable) begin
                result = 2'b10;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/extended_hamming_error_logger_saturating_counter.sv
// Event counter that restarts on clear and sticks at its all-ones maximum.
module saturating_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] base;

    // Next count: clear restarts from zero, an increment on the same cycle still counts.
    always_comb begin
        base    = clear ? '0 : count_q;
        count_d = base;
        if (increment && (base != '1)) begin
            count_d = base + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/extended_hamming_error_logger.sv
// Error logger for an extended Hamming checker: saturating counts, first-error
// capture with upgrade to uncorrectable, sticky overflow and a level interrupt.
module extended_hamming_error_logger
    import extended_hamming_error_logger_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     check_valid,
    input  logic [ADDRESS_WIDTH-1:0] check_address,
    input  logic                     correctable_error,
    input  logic                     uncorrectable_error,
    input  logic                     clear,
    input  logic [COUNTER_WIDTH-1:0] correctable_threshold,
    output logic [COUNTER_WIDTH-1:0] correctable_count,
    output logic [COUNTER_WIDTH-1:0] uncorrectable_count,
    output logic                     first_error_valid,
    output logic [ADDRESS_WIDTH-1:0] first_error_address,
    output logic                     first_error_uncorrectable,
    output logic                     overflow,
    output logic                     interrupt
);

    logic inc_correctable;
    logic inc_uncorrectable;
    logic error_event;

    logic                     first_error_valid_q,   first_error_valid_d;
    logic [ADDRESS_WIDTH-1:0] first_error_address_q, first_error_address_d;
    error_type_t              first_error_type_q,    first_error_type_d;
    logic                     overflow_q,            overflow_d;
    logic                     interrupt_q,           interrupt_d;

    logic [COUNTER_WIDTH-1:0] correctable_base;
    logic [COUNTER_WIDTH-1:0] correctable_next;
    logic                     uncorrectable_next_nonzero;

    assign {inc_correctable, inc_uncorrectable} =
        classify(check_valid, correctable_error, uncorrectable_error);
    assign error_event = inc_correctable | inc_uncorrectable;

    saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_correctable_counter (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (clear),
        .increment (inc_correctable),
        .count     (correctable_count)
    );

    saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_uncorrectable_counter (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (clear),
        .increment (inc_uncorrectable),
        .count     (uncorrectable_count)
    );

    // Capture and overflow update against the post-clear view of the capture register.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        first_error_valid_d   = clear ? 1'b0 : first_error_valid_q;
        first_error_address_d = clear ? '0 : first_error_address_q;
        first_error_type_d    = clear ? ERROR_CORRECTABLE : first_error_type_q;
        overflow_d            = clear ? 1'b0 : overflow_q;
        if (error_event) begin
            if (!first_error_valid_d ||
                (inc_uncorrectable && (first_error_type_d == ERROR_CORRECTABLE))) begin
                first_error_valid_d   = 1'b1;
                first_error_address_d = check_address;
                first_error_type_d    = inc_uncorrectable ? ERROR_UNCORRECTABLE : ERROR_CORRECTABLE;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Interrupt is derived from the counts the counters will hold after this edge.
    always_comb begin
        correctable_base = clear ? '0 : correctable_count;
        correctable_next = correctable_base;
        if (inc_correctable && (correctable_base != '1)) begin
            correctable_next = correctable_base + COUNTER_WIDTH'(1);
        end
        uncorrectable_next_nonzero = inc_uncorrectable | (!clear && (uncorrectable_count != '0));
        interrupt_d = uncorrectable_next_nonzero |
                      ((correctable_threshold != '0) && (correctable_next >= correctable_threshold));
    end

    // Capture, overflow and interrupt registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            first_error_valid_q   <= 1'b0;
            first_error_address_q <= '0;
            first_error_type_q    <= ERROR_CORRECTABLE;
            overflow_q            <= 1'b0;
            interrupt_q           <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
            first_error_valid_q   <= first_error_valid_d;
            first_error_address_q <= first_error_address_d;
            first_error_type_q    <= first_error_type_d;
            overflow_q            <= overflow_d;
            interrupt_q           <= interrupt_d;
        end
    end

    assign first_error_valid         = first_error_valid_q;
    assign first_error_address       = first_error_address_q;
    assign first_error_uncorrectable = (first_error_type_q == ERROR_UNCORRECTABLE);
    assign overflow                  = overflow_q;
    assign interrupt                 = interrupt_q;

endmodule

// File: tb/tb_extended_hamming_error_logger.sv
// Randomised and directed bench for extended_hamming_error_logger against a rule-level model.
module tb_extended_hamming_error_logger;

    localparam int AW      = 16;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clock;
    logic          resetn;
    logic          check_valid;
    logic [AW-1:0] check_address;
    logic          correctable_error;
    logic          uncorrectable_error;
    logic          clear;
    logic [CW-1:0] correctable_threshold;
    logic [CW-1:0] correctable_count;
    logic [CW-1:0] uncorrectable_count;
    logic          first_error_valid;
    logic [AW-1:0] first_error_address;
    logic          first_error_uncorrectable;
    logic          overflow;
    logic          interrupt;

    int checks = 0;
    int errors = 0;

    // Reference model state, in plain integers.
    int            m_cc;
    int            m_uc;
    bit            m_fv;
    int            m_fa;
    bit            m_fu;
    bit            m_ovf;
    bit            m_int;

    extended_hamming_error_logger #(.ADDRESS_WIDTH(AW), .COUNTER_WIDTH(CW)) dut (
        .clock                     (clock),
        .resetn                    (resetn),
        .check_valid               (check_valid),
        .check_address             (check_address),
        .correctable_error         (correctable_error),
        .uncorrectable_error       (uncorrectable_error),
        .clear                     (clear),
        .correctable_threshold     (correctable_threshold),
        .correctable_count         (correctable_count),
        .uncorrectable_count       (uncorrectable_count),
        .first_error_valid         (first_error_valid),
        .first_error_address       (first_error_address),
        .first_error_uncorrectable (first_error_uncorrectable),
        .overflow                  (overflow),
        .interrupt                 (interrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cc = 0; m_uc = 0; m_fv = 0; m_fa = 0; m_fu = 0; m_ovf = 0; m_int = 0;
    endtask

    // Applies the logger rules for one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit ev_u, ev_c;
        ev_u = check_valid && uncorrectable_error;
        ev_c = check_valid && correctable_error && !uncorrectable_error;
        if (clear) begin
            m_cc = 0; m_uc = 0; m_fv = 0; m_fa = 0; m_fu = 0; m_ovf = 0;
        end
        if (ev_u && m_uc < CNT_MAX) m_uc++;
        if (ev_c && m_cc < CNT_MAX) m_cc++;
        if (ev_u || ev_c) begin
            if (!m_fv || (ev_u && !m_fu)) begin
                m_fv = 1; m_fa = int'(check_address); m_fu = ev_u;
            end else begin
                m_ovf = 1;
            end
        end
        m_int = (m_uc != 0) ||
                ((correctable_threshold != 0) && (m_cc >= int'(correctable_threshold)));
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ccount"}, 32'(correctable_count),         32'(m_cc));
        check({tag, ".ucount"}, 32'(uncorrectable_count),       32'(m_uc));
        check({tag, ".fvalid"}, 32'(first_error_valid),         32'(m_fv));
        check({tag, ".faddr"},  32'(first_error_address),       32'(m_fa));
        check({tag, ".ftype"},  32'(first_error_uncorrectable), 32'(m_fu));
        check({tag, ".ovf"},    32'(overflow),                  32'(m_ovf));
        check({tag, ".irq"},    32'(interrupt),                 32'(m_int));
    endtask

    // Called at a falling edge: drive inputs, advance one cycle, check at the next falling edge.
    task automatic step(input string tag, input bit v, input int addr, input bit c, input bit u,
                        input bit clr, input int thr);
        check_valid           = v;
        check_address         = AW'(addr);
        correctable_error     = c;
        uncorrectable_error   = u;
        clear                 = clr;
        correctable_threshold = CW'(thr);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int thr);
        step(tag, 0, 0, 0, 0, 0, thr);
    endtask

    initial begin
        resetn = 1'b0;
        check_valid = 0; check_address = '0; correctable_error = 0;
        uncorrectable_error = 0; clear = 0; correctable_threshold = '0;
        model_reset();
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        check_all("reset");

        // First correctable error is captured, threshold 0 keeps the interrupt low.
        step("first_corr", 1, 'h0040, 1, 0, 0, 0);
        check("first_corr.addr_direct", 32'(first_error_address), 32'h0040);

        // Correctable, upgrade to uncorrectable, then overflow on the third error.
        step("seq_clr", 0, 0, 0, 0, 1, 0);
        step("seq_c1",  1, 'h0010, 1, 0, 0, 0);
        step("seq_u",   1, 'h0020, 0, 1, 0, 0);
        check("seq_u.no_ovf_yet", 32'(overflow), 32'd0);
        step("seq_c2",  1, 'h0030, 1, 0, 0, 0);
        check("seq_c2.ovf_direct", 32'(overflow), 32'd1);

        // Both flags count as uncorrectable only; flags without valid are ignored.
        step("both_clr", 0, 0, 0, 0, 1, 0);
        step("both",     1, 'h0005, 1, 1, 0, 0);
        step("novalid",  0, 'h0099, 1, 1, 0, 0);
        step("novalid2", 0, 'h0099, 1, 0, 0, 0);

        // Saturation and threshold crossing.
        step("sat_clr", 0, 0, 0, 0, 1, 3);
        for (int i = 0; i < 300; i++) begin
            step("sat", 1, i, 1, 0, 0, 3);
        end
        check("sat.hold255", 32'(correctable_count), 32'(CNT_MAX));

        // Threshold lowered without a new event asserts the interrupt.
        step("thr_clr", 0, 0, 0, 0, 1, 0);
        step("thr_ev1", 1, 'h0001, 1, 0, 0, 0);
        step("thr_ev2", 1, 'h0002, 1, 0, 0, 5);
        idle("thr_low", 2);
        check("thr_low.irq_direct", 32'(interrupt), 32'd1);

        // Clear together with a new correctable error after prior errors.
        step("pre_u", 1, 'h0003, 0, 1, 0, 0);
        step("clr_ev", 1, 'h0077, 1, 0, 1, 0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step("rand", r < 70, int'($urandom_range(0, 65535)), 1'($urandom),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 39) == 0),
                 (($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12))));
        end

        // Asynchronous reset between clock edges.
        step("pre_rst", 1, 'h0123, 0, 1, 0, 2);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clock);
        @(negedge clock);
        check_valid = 0; correctable_error = 0; uncorrectable_error = 0;
        correctable_threshold = '0;
        resetn = 1'b1;
        check_all("rst_release");
        idle("post_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/extended_hamming_error_logger.md
Name: extended_hamming_error_logger

Overview:
- Sequential stage directly downstream of the extended Hamming checker; consumes its correctable/uncorrectable flags, qualified by a valid strobe and the address of the checked word.
- Keeps saturating error counters, captures the first error (address and type), flags overflow of that capture, and raises a level interrupt.
- Sits beside each ECC-protected memory or register bank as the error-reporting element read by software or a scrubber.

Parameters:
- ADDRESS_WIDTH, 16, width of check_address and first_error_address.
- COUNTER_WIDTH, 8, width of each saturating error counter (≥1).

Ports:
- clock  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- check_valid  input  1  a checker result is present this cycle.
- check_address  input  ADDRESS_WIDTH  address of the word being checked.
- correctable_error  input  1  checker single-bit error flag.
- uncorrectable_error  input  1  checker double-bit error flag.
- clear  input  1  synchronous clear of counters, capture, overflow and interrupt.
- correctable_threshold  input  COUNTER_WIDTH  interrupt threshold for correctable count; 0 disables the correctable contribution.
- correctable_count  output  COUNTER_WIDTH  saturating count of correctable events.
- uncorrectable_count  output  COUNTER_WIDTH  saturating count of uncorrectable events.
- first_error_valid  output  1  capture register holds an error.
- first_error_address  output  ADDRESS_WIDTH  captured address.
- first_error_uncorrectable  output  1  captured error type (1 = uncorrectable).
- overflow  output  1  sticky: an error arrived that could not be captured.
- interrupt  output  1  registered level interrupt.

Behaviour:
- Clock: clock. Reset: resetn, asynchronous, active-low. All outputs reset to 0.
- Event classification, only when check_valid=1:
  - Both flags set: one uncorrectable event; correctable not counted.
  - Only correctable_error: one correctable event.
  - Neither flag: no event.
  - Flags are ignored when check_valid=0.
- Counters: next = (clear ? 0 : current) + inc, saturating at 2^COUNTER_WIDTH-1 with no wrap. An event in the same cycle as clear therefore leaves the count at 1.
- Capture:
  - Effective state S = clear ? empty : current.
  - Event with S empty: load address and type, set first_error_valid.
  - Uncorrectable event with S holding a correctable entry: overwrite with the uncorrectable one (upgrade). Overflow is not set.
  - Any other event with S valid: capture unchanged, overflow set.
  - Overflow is sticky until clear. It is set in the same cycle as clear if the event hits the newly empty S and a second event arrives (impossible: one event per cycle), so it stays 0 after a clear cycle.
- Interrupt:
  - Registered: interrupt_next = (uncorrectable_count_next != 0) | (correctable_threshold != 0 & correctable_count_next >= correctable_threshold).
  - Asserts the cycle after the triggering event (1-cycle latency from check_valid to every output).
  - Deasserts the cycle after clear unless an event on the clear cycle re-triggers it.
  - Threshold changes are evaluated every cycle, so lowering the threshold can assert the interrupt without a new event.
- Reset mid-operation: immediate asynchronous return of all state to 0. No pending event is retained.

Decomposition:
- Package extended_hamming_error_logger_pkg:
  - enum error_type_t {ERROR_CORRECTABLE, ERROR_UNCORRECTABLE}.
  - Function classify(valid, correctable, uncorrectable) returning {inc_correctable, inc_uncorrectable}.
- One sub-module, saturating_counter (parameter WIDTH; ports clock, resetn, clear, increment, count), instantiated twice.

Test Plan:
- Reset, then check_valid=1, correctable=1, addr=0x0040 -> next cycle: correctable_count=1, first_error_valid=1, addr=0x0040, uncorrectable=0, interrupt=0 (threshold=0).
- Correctable at 0x0010, then uncorrectable at 0x0020, then correctable at 0x0030 -> capture addr=0x0020 type=1, overflow=1 only after third event, uncorrectable_count=1, interrupt=1.
- Both flags with check_valid=1 at 0x0005 -> uncorrectable_count=1, correctable_count=0. Flags with check_valid=0 -> no change.
- COUNTER_WIDTH=8, 300 correctable events -> correctable_count holds 255. Threshold=3 -> interrupt rises the cycle after the 3rd event.
- clear together with a correctable event at 0x0077 after prior errors -> counts become {1,0}, capture=0x0077 type 0, overflow=0, interrupt=0.
- resetn pulsed low mid-stream, asynchronously without a clock edge -> all outputs 0 immediately and after release.
